matrix_mult_seq_ctrl: RTL

//  Sequencer for a time-multiplexed matrix multiply C = A x B over square NxN matrices (1 <= N <= MAX_SIZE).

---
 rtl/matrix_mult_pkg.sv | 26 ++
 rtl/mm_index_counter.sv | 52 +++++
 rtl/matrix_mult_seq_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/matrix_mult_pkg.sv
// Shared types and helpers for the sequential matrix-multiply controller.
// Holds the controller state enum, a constant clog2 and the address-width derivation.
package matrix_mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } mm_state_e;

   localparam int MM_MAX_SIZE_DEF = 10;

   // Never returns 0 so that a degenerate size still yields a 1-bit field.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int mm_addr_w(input int max_size);
      return clog2(max_size * max_size);
   endfunction

endpackage

// File: rtl/mm_index_counter.sv
// Nested i/j/k step counter bounded by n (k innermost, i outermost).
// Ports: clk, rst (sync high), clr, en, n -> i, j, k, last_k, last_all.
module mm_index_counter
   import matrix_mult_pkg::*;
#(
   parameter int SW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [SW-1:0] n,
   output logic [SW-1:0] i,
   output logic [SW-1:0] j,
   output logic [SW-1:0] k,
   output logic          last_k,
   output logic          last_all
);

   localparam logic [SW-1:0] ONE = SW'(1);

   logic [SW-1:0] top;
   logic          last_j;
   logic          last_i;

   assign top      = n - ONE;
   assign last_k   = (k == top);
   assign last_j   = (j == top);
   assign last_i   = (i == top);
   assign last_all = last_k && last_j && last_i;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (en) begin
         if (!last_k) begin
            k <= k + ONE;
         end else begin
            k <= '0;
            if (!last_j) begin
               j <= j + ONE;
            end else begin
               j <= '0;
               i <= last_i ? '0 : i + ONE;
            end
         end
      end
   end

endmodule

// File: rtl/matrix_mult_seq_ctrl.sv
// Time-multiplexed C = A x B sequencer: row-major reads of A/B, one MAC, one C write per element.
// Ports: clk, rst, start, matrix_size -> busy, done, size_err, a/b_addr, rd_en; a/b_rdata in;
//        c_we, c_addr, c_wdata out. Define MM_CYCLE_COUNT_EN to add cycle_count[31:0].
module matrix_mult_seq_ctrl
   import matrix_mult_pkg::*;
#(
   parameter  int MAX_SIZE   = MM_MAX_SIZE_DEF,
   parameter  int DATA_WIDTH = 32,
   localparam int ADDR_W     = mm_addr_w(MAX_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [31:0]           matrix_size,
   output logic                  busy,
   output logic                  done,
   output logic                  size_err,
   output logic [ADDR_W-1:0]     a_addr,
   output logic [ADDR_W-1:0]     b_addr,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] a_rdata,
   input  logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  c_we,
   output logic [ADDR_W-1:0]     c_addr,
`ifdef MM_CYCLE_COUNT_EN
   output logic [31:0]           cycle_count,
`endif
   output logic [DATA_WIDTH-1:0] c_wdata
);

   localparam int SW = clog2(MAX_SIZE + 1);

   mm_state_e state;

   logic [SW-1:0] n_q;
   logic [SW-1:0] n_eff;
   logic          size_ok;
   logic          accept;
   logic          issue;
   logic          cnt_clr;

   logic [SW-1:0] ci;
   logic [SW-1:0] cj;
   logic [SW-1:0] ck;
   logic          c_last_k;
   logic          c_last_all;

   // Tags of the read currently on the bus.
   logic              t_first;
   logic              t_last;
   logic              t_last_all;
   logic [ADDR_W-1:0] t_caddr;

   // Same tags one cycle later, aligned with returning read data.
   logic              p_valid;
   logic              p_first;
   logic              p_last;
   logic [ADDR_W-1:0] p_caddr;

   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] prod;
   logic [DATA_WIDTH-1:0] mac_sum;

   function automatic logic [ADDR_W-1:0] rc_addr(
      input logic [SW-1:0] r,
      input logic [SW-1:0] c
   );
      return ADDR_W'(r) * ADDR_W'(MAX_SIZE) + ADDR_W'(c);
   endfunction

   assign size_ok = (matrix_size != '0) &&
                    (matrix_size <= 32'(MAX_SIZE));
   assign accept  = (state == IDLE) && start && size_ok;
   assign issue   = accept || ((state == RUN) && !t_last_all);

   // In IDLE the live request drives the bound so the first step
   // issued on the accepting edge already sees the new N.
   assign n_eff   = (state == IDLE) ? matrix_size[SW-1:0] : n_q;
   assign cnt_clr = (state != RUN) && !accept;

   mm_index_counter #(
      .SW (SW)
   ) u_idx (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .en       (issue),
      .n        (n_eff),
      .i        (ci),
      .j        (cj),
      .k        (ck),
      .last_k   (c_last_k),
      .last_all (c_last_all)
   );

   assign prod    = a_rdata * b_rdata;
   assign mac_sum = (p_first ? '0 : acc) + prod;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         n_q        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         size_err   <= 1'b0;
         rd_en      <= 1'b0;
         a_addr     <= '0;
         b_addr     <= '0;
         t_first    <= 1'b0;
         t_last     <= 1'b0;
         t_last_all <= 1'b0;
         t_caddr    <= '0;
         p_valid    <= 1'b0;
         p_first    <= 1'b0;
         p_last     <= 1'b0;
         p_caddr    <= '0;
         acc        <= '0;
         c_we       <= 1'b0;
         c_addr     <= '0;
         c_wdata    <= '0;
      end else begin
         done    <= 1'b0;
         c_we    <= 1'b0;
         p_valid <= rd_en;
         p_first <= t_first;
         p_last  <= t_last;
         p_caddr <= t_caddr;

         if (p_valid) begin
            acc <= mac_sum;
            if (p_last) begin
               c_we    <= 1'b1;
               c_addr  <= p_caddr;
               c_wdata <= mac_sum;
            end
         end

         rd_en <= issue;
         if (issue) begin
            a_addr     <= rc_addr(ci, ck);
            b_addr     <= rc_addr(ck, cj);
            t_caddr    <= rc_addr(ci, cj);
            t_first    <= (ck == '0);
            t_last     <= c_last_k;
            t_last_all <= c_last_all;
         end

         unique case (state)
            IDLE: begin
               if (start) begin
                  size_err <= !size_ok;
                  if (size_ok) begin
                     n_q   <= matrix_size[SW-1:0];
                     busy  <= 1'b1;
                     state <= RUN;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            RUN: begin
               if (t_last_all) state <= DRAIN;
            end
            DRAIN: begin
               // The only write that can land in DRAIN is the final one.
               if (c_we) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MM_CYCLE_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count <= '0;
      end else if ((state == IDLE) && start) begin
         cycle_count <= '0;
      end else if (busy) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end
`endif

endmodule
